// File: rtl/tcb_gpio_pkg.sv
// Shared constants for the TCB GPIO controller: bus geometry, register
// indices (decoded from adr[5:2]) and the byte-enable expansion helper.
package tcb_gpio_pkg;

  localparam int unsigned ADR_W = 6;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned REG_W = 32;
  localparam int unsigned BEN_W = REG_W / 8;

  localparam logic [IDX_W-1:0] GPIO_OUT     = 4'd0;
  localparam logic [IDX_W-1:0] GPIO_OE      = 4'd1;
  localparam logic [IDX_W-1:0] GPIO_IN      = 4'd2;
  localparam logic [IDX_W-1:0] GPIO_OUT_SET = 4'd3;
  localparam logic [IDX_W-1:0] GPIO_OUT_CLR = 4'd4;
  localparam logic [IDX_W-1:0] GPIO_RISE_EN = 4'd5;
  localparam logic [IDX_W-1:0] GPIO_FALL_EN = 4'd6;
  localparam logic [IDX_W-1:0] GPIO_STATUS  = 4'd7;

  // Expand per-byte enables into a per-bit write mask.
  function automatic logic [REG_W-1:0] ben_mask(input logic [BEN_W-1:0] ben);
    logic [REG_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < BEN_W; i++) begin
      m[8*i +: 8] = {8{ben[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/tcb_gpio_cdc.sv
// Input synchroniser: STAGES-deep flip-flop chain per bit, reset to 0.
// STAGES = 0 turns it into a wire for inputs that are already synchronous.
// Ports: i_clk, i_rst_n (async active-low), i_d (raw pins), o_q (synchronised).
module tcb_gpio_cdc #(
  parameter int unsigned W      = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  if (STAGES == 0) begin : g_bypass
    logic w_unused_clk;
    assign w_unused_clk = i_clk ^ i_rst_n;
    assign o_q          = i_d;
  end else begin : g_sync
    logic [STAGES-1:0][W-1:0] r_chain;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_chain <= '0;
      end else begin
        r_chain[0] <= i_d;
        for (int unsigned s = 1; s < STAGES; s++) begin
          r_chain[s] <= r_chain[s-1];
        end
      end
    end

    assign o_q = r_chain[STAGES-1];
  end

endmodule

// File: rtl/tcb_gpio_irq.sv
// TCB-attached GPIO controller with input synchroniser, atomic set/clear of
// output bits, per-pin rising/falling edge detection, sticky W1C status and a
// registered level interrupt.
// Ports: i_clk/i_rst_n; TCB slave i_tcb_vld/wen/adr/ben/wdt -> o_tcb_rdt (1-cycle
// read latency), o_tcb_rdy (always 1), o_tcb_err (combinational); pins
// o_gpio_o/o_gpio_e/i_gpio_i; o_irq level interrupt.
module tcb_gpio_irq
  import tcb_gpio_pkg::*;
#(
  parameter int unsigned    GW      = 32,
  parameter int unsigned    DW      = 32,
  parameter int unsigned    CFG_CDC = 2,
  parameter logic [GW-1:0]  RST_O   = '0,
  parameter logic [GW-1:0]  RST_E   = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_tcb_vld,
  input  logic              i_tcb_wen,
  input  logic [ADR_W-1:0]  i_tcb_adr,
  input  logic [DW/8-1:0]   i_tcb_ben,
  input  logic [DW-1:0]     i_tcb_wdt,
  output logic [DW-1:0]     o_tcb_rdt,
  output logic              o_tcb_rdy,
  output logic              o_tcb_err,
  output logic [GW-1:0]     o_gpio_o,
  output logic [GW-1:0]     o_gpio_e,
  input  logic [GW-1:0]     i_gpio_i,
  output logic              o_irq
);

  if (GW > DW || GW == 0 || DW != 32) begin : g_param_err
    $error("tcb_gpio_irq: need DW == 32 and 1 <= GW <= DW");
  end

  logic             w_trn;
  logic             w_wr;
  logic             w_mapped;
  logic [IDX_W-1:0] w_idx;
  logic [DW-1:0]    w_bmask_full;
  logic [GW-1:0]    w_bmask;
  logic [GW-1:0]    w_wdt_m;
  logic [GW-1:0]    w_clr;
  logic [GW-1:0]    w_sync;
  logic [GW-1:0]    w_rise;
  logic [GW-1:0]    w_fall;
  logic [DW-1:0]    w_rdata;
  logic             w_unused;

  logic [GW-1:0]    r_out;
  logic [GW-1:0]    r_oe;
  logic [GW-1:0]    r_ren;
  logic [GW-1:0]    r_fen;
  logic [GW-1:0]    r_status;
  logic [GW-1:0]    r_prev;
  logic [DW-1:0]    r_rdt;
  logic             r_irq;

  // Bus decode; the slave never stalls so every valid is a transfer.
  assign w_trn        = i_tcb_vld;
  assign w_idx        = i_tcb_adr[5:2];
  assign w_mapped     = (w_idx <= GPIO_STATUS);
  assign w_wr         = w_trn & i_tcb_wen & w_mapped & (w_idx != GPIO_IN);
  assign w_bmask_full = ben_mask(i_tcb_ben);
  assign w_bmask      = w_bmask_full[GW-1:0];
  assign w_wdt_m      = i_tcb_wdt[GW-1:0] & w_bmask;
  assign w_unused     = ^{i_tcb_wdt, i_tcb_adr[1:0], w_bmask_full};

  assign o_tcb_rdy = 1'b1;
  assign o_tcb_err = w_trn & (~w_mapped | (i_tcb_wen & (w_idx == GPIO_IN)));

  tcb_gpio_cdc #(
    .W      (GW),
    .STAGES (CFG_CDC)
  ) u_cdc (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_gpio_i),
    .o_q     (w_sync)
  );

  // Edge detect on the synchronised pins.
  assign w_rise = w_sync & ~r_prev;
  assign w_fall = ~w_sync & r_prev;
  assign w_clr  = (w_wr && (w_idx == GPIO_STATUS)) ? w_wdt_m : '0;

  // Read mux; write-only and unmapped indices read as zero.
  always_comb begin
    w_rdata = '0;
    case (w_idx)
      GPIO_OUT:     w_rdata = DW'(r_out);
      GPIO_OE:      w_rdata = DW'(r_oe);
      GPIO_IN:      w_rdata = DW'(w_sync);
      GPIO_RISE_EN: w_rdata = DW'(r_ren);
      GPIO_FALL_EN: w_rdata = DW'(r_fen);
      GPIO_STATUS:  w_rdata = DW'(r_status);
      default:      w_rdata = '0;
    endcase
  end

  // Control register file.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out <= RST_O;
      r_oe  <= RST_E;
      r_ren <= '0;
      r_fen <= '0;
    end else if (w_wr) begin
      case (w_idx)
        GPIO_OUT:     r_out <= (r_out & ~w_bmask) | w_wdt_m;
        GPIO_OE:      r_oe  <= (r_oe  & ~w_bmask) | w_wdt_m;
        GPIO_OUT_SET: r_out <= r_out | w_wdt_m;
        GPIO_OUT_CLR: r_out <= r_out & ~w_wdt_m;
        GPIO_RISE_EN: r_ren <= (r_ren & ~w_bmask) | w_wdt_m;
        GPIO_FALL_EN: r_fen <= (r_fen & ~w_bmask) | w_wdt_m;
        default:      ;
      endcase
    end
  end

  // Sticky status: a new edge outranks a same-cycle write-1-clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev   <= '0;
      r_status <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_prev   <= w_sync;
      r_status <= (r_status & ~w_clr) | (w_rise & r_ren) | (w_fall & r_fen);
      r_irq    <= |r_status;
    end
  end

  // Read data captures pre-update register values and holds between reads.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdt <= '0;
    end else if (w_trn && !i_tcb_wen) begin
      r_rdt <= w_rdata;
    end
  end

  assign o_tcb_rdt = r_rdt;
  assign o_gpio_o  = r_out;
  assign o_gpio_e  = r_oe;
  assign o_irq     = r_irq;

endmodule

// File: tb/tb_tcb_gpio_irq.sv
// Directed bench for tcb_gpio_irq: a table of bus transfers with expected
// results, then hand-written sequences for edge/irq timing and GW=8.
module tb_tcb_gpio_irq;

  localparam logic [31:0] RST_O = 32'h1234_5678;
  localparam logic [31:0] RST_E = 32'h0000_FFFF;
  localparam int NV = 18;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vld, wen;
  logic [5:0]  adr;
  logic [3:0]  ben;
  logic [31:0] wdt;
  logic [31:0] gpio_i;

  logic [31:0] rdt, gpio_o, gpio_e;
  logic        rdy, err, irq;
  logic [31:0] rdt8;
  logic [7:0]  gpio_o8, gpio_e8;
  logic        rdy8, err8, irq8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tcb_gpio_irq #(
    .GW (32), .DW (32), .CFG_CDC (2), .RST_O (RST_O), .RST_E (RST_E)
  ) u_dut (
    .i_clk (clk), .i_rst_n (rst_n),
    .i_tcb_vld (vld), .i_tcb_wen (wen), .i_tcb_adr (adr),
    .i_tcb_ben (ben), .i_tcb_wdt (wdt),
    .o_tcb_rdt (rdt), .o_tcb_rdy (rdy), .o_tcb_err (err),
    .o_gpio_o (gpio_o), .o_gpio_e (gpio_e), .i_gpio_i (gpio_i),
    .o_irq (irq)
  );

  tcb_gpio_irq #(
    .GW (8), .DW (32), .CFG_CDC (0), .RST_O (8'h00), .RST_E (8'h00)
  ) u_dut8 (
    .i_clk (clk), .i_rst_n (rst_n),
    .i_tcb_vld (vld), .i_tcb_wen (wen), .i_tcb_adr (adr),
    .i_tcb_ben (ben), .i_tcb_wdt (wdt),
    .o_tcb_rdt (rdt8), .o_tcb_rdy (rdy8), .o_tcb_err (err8),
    .o_gpio_o (gpio_o8), .o_gpio_e (gpio_e8), .i_gpio_i (gpio_i[7:0]),
    .o_irq (irq8)
  );

  typedef struct {
    logic        wen;
    logic [5:0]  adr;
    logic [3:0]  ben;
    logic [31:0] wdt;
    logic        exp_err;
    logic        chk_rdt;
    logic [31:0] exp_rdt;
    logic [31:0] exp_out;
    logic [31:0] exp_oe;
  } vec_t;

  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // One transfer: drive at negedge, sample err mid-cycle, release after posedge.
  task automatic bus(input logic w, input logic [5:0] a, input logic [3:0] b,
                     input logic [31:0] d, output logic e);
    @(negedge clk);
    vld = 1'b1; wen = w; adr = a; ben = b; wdt = d;
    #1 e = err;
    @(posedge clk);
    #1 vld = 1'b0; wen = 1'b0;
  endtask

  logic e;

  initial begin
    //            wen   adr    ben   wdt           err   chk   rdt           out           oe
    vecs[0]  = '{1'b1, 6'h00, 4'hF, 32'hA5A5_0000, 1'b0, 1'b0, 32'h0,        32'hA5A5_0000, 32'h0000_FFFF};
    vecs[1]  = '{1'b1, 6'h0C, 4'h1, 32'h0000_00FF, 1'b0, 1'b0, 32'h0,        32'hA5A5_00FF, 32'h0000_FFFF};
    vecs[2]  = '{1'b1, 6'h10, 4'hF, 32'h0500_0000, 1'b0, 1'b0, 32'h0,        32'hA0A5_00FF, 32'h0000_FFFF};
    vecs[3]  = '{1'b0, 6'h00, 4'h0, 32'h0,         1'b0, 1'b1, 32'hA0A5_00FF, 32'hA0A5_00FF, 32'h0000_FFFF};
    vecs[4]  = '{1'b1, 6'h04, 4'h5, 32'h1234_5678, 1'b0, 1'b0, 32'h0,        32'hA0A5_00FF, 32'h0034_FF78};
    vecs[5]  = '{1'b0, 6'h04, 4'h0, 32'h0,         1'b0, 1'b1, 32'h0034_FF78, 32'hA0A5_00FF, 32'h0034_FF78};
    vecs[6]  = '{1'b0, 6'h24, 4'h0, 32'h0,         1'b1, 1'b1, 32'h0,        32'hA0A5_00FF, 32'h0034_FF78};
    vecs[7]  = '{1'b0, 6'h00, 4'h0, 32'h0,         1'b0, 1'b1, 32'hA0A5_00FF, 32'hA0A5_00FF, 32'h0034_FF78};
    vecs[8]  = '{1'b0, 6'h0C, 4'h0, 32'h0,         1'b0, 1'b1, 32'h0,        32'hA0A5_00FF, 32'h0034_FF78};
    vecs[9]  = '{1'b1, 6'h08, 4'hF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0,        32'hA0A5_00FF, 32'h0034_FF78};
    vecs[10] = '{1'b0, 6'h08, 4'h0, 32'h0,         1'b0, 1'b1, 32'h0000_0050, 32'hA0A5_00FF, 32'h0034_FF78};
    vecs[11] = '{1'b1, 6'h14, 4'hF, 32'h0000_0008, 1'b0, 1'b0, 32'h0,        32'hA0A5_00FF, 32'h0034_FF78};
    vecs[12] = '{1'b0, 6'h14, 4'h0, 32'h0,         1'b0, 1'b1, 32'h0000_0008, 32'hA0A5_00FF, 32'h0034_FF78};
    vecs[13] = '{1'b0, 6'h1C, 4'h0, 32'h0,         1'b0, 1'b1, 32'h0,        32'hA0A5_00FF, 32'h0034_FF78};
    vecs[14] = '{1'b1, 6'h00, 4'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0,        32'hA0A5_00FF, 32'h0034_FF78};
    vecs[15] = '{1'b0, 6'h3C, 4'h0, 32'h0,         1'b1, 1'b1, 32'h0,        32'hA0A5_00FF, 32'h0034_FF78};
    vecs[16] = '{1'b1, 6'h20, 4'hF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0,        32'hA0A5_00FF, 32'h0034_FF78};
    vecs[17] = '{1'b0, 6'h18, 4'h0, 32'h0,         1'b0, 1'b1, 32'h0,        32'hA0A5_00FF, 32'h0034_FF78};

    rst_n = 1'b0; vld = 1'b0; wen = 1'b0; adr = '0; ben = '0; wdt = '0;
    gpio_i = 32'h0000_0050;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Reset asserted in the middle of a write must abort it.
    @(negedge clk);
    vld = 1'b1; wen = 1'b1; adr = 6'h00; ben = 4'hF; wdt = 32'hFFFF_FFFF;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 vld = 1'b0; wen = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst gpio_o", gpio_o, RST_O);
    chk("rst gpio_e", gpio_e, RST_E);
    chk("rst irq", 32'(irq), 32'h0);
    chk("rst rdt", rdt, 32'h0);
    chk("rst rdy", 32'(rdy), 32'h1);
    chk("rst gpio_o8", 32'(gpio_o8), 32'h0);

    for (int i = 0; i < NV; i++) begin
      bus(vecs[i].wen, vecs[i].adr, vecs[i].ben, vecs[i].wdt, e);
      chk($sformatf("v%0d err", i), 32'(e), 32'(vecs[i].exp_err));
      if (vecs[i].chk_rdt) chk($sformatf("v%0d rdt", i), rdt, vecs[i].exp_rdt);
      chk($sformatf("v%0d gpio_o", i), gpio_o, vecs[i].exp_out);
      chk($sformatf("v%0d gpio_e", i), gpio_e, vecs[i].exp_oe);
      chk($sformatf("v%0d irq", i), 32'(irq), 32'h0);
    end

    // Rise on pin 3: status after 3 edges, irq after 4 (bypass instance: 1 and 2).
    @(negedge clk) gpio_i = 32'h0000_0058;
    @(posedge clk); #1;
    chk("rise e1 irq8", 32'(irq8), 32'h0);
    @(posedge clk); #1;
    chk("rise e2 irq8", 32'(irq8), 32'h1);
    chk("rise e2 irq", 32'(irq), 32'h0);
    @(posedge clk); #1;
    chk("rise e3 irq", 32'(irq), 32'h0);
    @(posedge clk); #1;
    chk("rise e4 irq", 32'(irq), 32'h1);
    bus(1'b0, 6'h1C, 4'h0, 32'h0, e);
    chk("status after rise", rdt, 32'h0000_0008);

    // Fall with FALL_EN clear is discarded; status stays set.
    @(negedge clk) gpio_i = 32'h0000_0050;
    repeat (4) @(posedge clk);
    #1;
    chk("fall ignored irq", 32'(irq), 32'h1);

    // Rise coincides with a write-1-clear of the same bit: set wins.
    @(negedge clk) gpio_i = 32'h0000_0058;
    @(posedge clk);
    @(posedge clk);
    bus(1'b1, 6'h1C, 4'hF, 32'h0000_0008, e);
    chk("coinc irq e3", 32'(irq), 32'h1);
    @(posedge clk); #1;
    chk("coinc irq e4", 32'(irq), 32'h1);
    bus(1'b0, 6'h1C, 4'h0, 32'h0, e);
    chk("coinc status", rdt, 32'h0000_0008);

    // Plain write-1-clear: irq drops one cycle after status.
    bus(1'b1, 6'h1C, 4'hF, 32'h0000_0008, e);
    chk("w1c irq same", 32'(irq), 32'h1);
    @(posedge clk); #1;
    chk("w1c irq next", 32'(irq), 32'h0);
    bus(1'b0, 6'h1C, 4'h0, 32'h0, e);
    chk("w1c status", rdt, 32'h0);

    // GW=8: bits above the GPIO width are dropped and read back as 0.
    bus(1'b1, 6'h00, 4'hF, 32'hFFFF_FFFF, e);
    chk("gw8 gpio_o", 32'(gpio_o8), 32'h0000_00FF);
    chk("gw32 gpio_o", gpio_o, 32'hFFFF_FFFF);
    bus(1'b0, 6'h00, 4'h0, 32'h0, e);
    chk("gw8 rdt", rdt8, 32'h0000_00FF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
